// File: rtl/buffer_ctrl_pkg.sv
// Shared widths, state encoding and configuration checks for the buffer pointer/flow-control stage.
package buffer_ctrl_pkg;

  localparam int SIZE_DFLT = 16;
  localparam int K_DFLT    = 4;
  localparam int J_DFLT    = 8;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Word-pointer width for a buffer of `size` words.
  function automatic int ptr_w(input int size);
    return $clog2(size);
  endfunction

  // Occupancy counter must hold 0..size inclusive.
  function automatic int cnt_w(input int size);
    return $clog2(size) + 1;
  endfunction

  localparam int AW_DFLT = $clog2(SIZE_DFLT);
  localparam int CW_DFLT = $clog2(SIZE_DFLT) + 1;

  // Pointers wrap naturally only if SIZE is a power of two and beats never straddle the end.
  function automatic bit cfg_ok(input int size, input int k, input int j);
    return (size > 0) && ((size & (size - 1)) == 0) &&
           (k > 0) && (j > 0) && (size % k == 0) && (size % j == 0);
  endfunction

endpackage

// File: rtl/buffer_ctrl_ptr.sv
// Modulo-SIZE word pointer: steps by STEP on inc, synchronous load has priority.
// Single-cycle update, no handshake of its own.
module buf_ptr
  import buffer_ctrl_pkg::*;
#(
  parameter int SIZE = SIZE_DFLT,
  parameter int STEP = K_DFLT,
  parameter int AW   = ptr_w(SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  output logic [AW-1:0] ptr
);

  localparam logic [AW-1:0] STEP_W = AW'(STEP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_val;
    end else if (inc) begin
      ptr <= ptr + STEP_W;
    end
  end

endmodule

// File: rtl/buffer_ctrl.sv
// Pointer/occupancy control for a K-word-write, J-word-read parallel buffer with drain-then-discard flush.
// Latency: ld counted at the same edge, out_valid earliest next cycle; in_ready drops when < K words free.
module buffer_ctrl
  import buffer_ctrl_pkg::*;
#(
  parameter int SIZE = SIZE_DFLT,
  parameter int K    = K_DFLT,
  parameter int J    = J_DFLT,
  parameter int AW   = ptr_w(SIZE),
  parameter int CW   = cnt_w(SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  input  logic          flush,
  output logic          ld,
  output logic [AW-1:0] write_add,
  output logic [AW-1:0] read_add,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          flushing
);

  if (!cfg_ok(SIZE, K, J)) begin : g_cfg_bad
    $fatal(1, "buffer_ctrl: SIZE must be a power of two and a multiple of K and J");
  end

  localparam logic [CW-1:0] SIZE_C = CW'(SIZE);
  localparam logic [CW-1:0] K_C    = CW'(K);
  localparam logic [CW-1:0] J_C    = CW'(J);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d, count_after_rd;
  logic          wr, rd, drain_done;

  assign in_ready  = (state_q == ST_RUN) && ((SIZE_C - count_q) >= K_C);
  assign out_valid = (count_q >= J_C);
  assign wr        = in_valid & in_ready;
  assign rd        = out_valid & out_ready;
  assign ld        = wr;

  // A read in the last full-beat cycle of FLUSH also ends the flush on the same edge.
  assign count_after_rd = rd ? (count_q - J_C) : count_q;
  assign drain_done     = (state_q == ST_FLUSH) && (count_after_rd < J_C);

  always_comb begin
    state_d = state_q;
    count_d = count_after_rd + (wr ? K_C : '0);
    if (state_q == ST_RUN) begin
      if (flush) state_d = ST_FLUSH;
    end else if (drain_done) begin
      state_d = ST_RUN;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  buf_ptr #(.SIZE(SIZE), .STEP(K), .AW(AW)) u_wr_ptr (
    .clk      (clk),
    .rst      (rst),
    .inc      (wr),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (write_add)
  );

  // Leftover partial words are dropped by realigning the read side onto the write side.
  buf_ptr #(.SIZE(SIZE), .STEP(J), .AW(AW)) u_rd_ptr (
    .clk      (clk),
    .rst      (rst),
    .inc      (rd),
    .load     (drain_done),
    .load_val (write_add),
    .ptr      (read_add)
  );

  assign count    = count_q;
  assign full     = (count_q == SIZE_C);
  assign empty    = (count_q == '0);
  assign flushing = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_buffer_ctrl.sv
// Randomized + directed bench: a word-queue reference model feeds a read scoreboard checked by a separate monitor.
module tb_buffer_ctrl;
  localparam int SIZE = 16;
  localparam int K    = 4;
  localparam int J    = 8;
  localparam int AW   = 4;
  localparam int CW   = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic          in_ready, out_valid, ld, full, empty, flushing;
  logic [AW-1:0] write_add, read_add;
  logic [CW-1:0] count;

  buffer_ctrl #(.SIZE(SIZE), .K(K), .J(J)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush), .ld(ld),
    .write_add(write_add), .read_add(read_add), .count(count),
    .full(full), .empty(empty), .flushing(flushing)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: stored words as a token queue, plus pointer positions.
  int q[$];
  int exp_rd[$];
  int m_wptr = 0, m_rptr = 0;
  bit m_flush = 0;
  int tok = 1000;
  int cur_tok = 0;
  int mem [SIZE];
  bit pend = 0;
  int n_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ir();
    return !m_flush && (SIZE - q.size() >= K);
  endfunction

  function automatic bit m_ov();
    return q.size() >= J;
  endfunction

  task automatic cycle(input bit v, input bit r, input bit f);
    bit wr, rd;
    @(negedge clk);
    in_valid  = v;
    out_ready = r;
    flush     = f;
    cur_tok   = tok;
    #1;
    chk("in_ready",  in_ready,  m_ir());
    chk("out_valid", out_valid, m_ov());
    chk("count",     count,     q.size());
    chk("full",      full,      q.size() == SIZE);
    chk("empty",     empty,     q.size() == 0);
    chk("flushing",  flushing,  m_flush);
    chk("write_add", write_add, m_wptr);
    chk("read_add",  read_add,  m_rptr);
    chk("ld",        ld,        v && m_ir());
    wr = v && m_ir();
    rd = r && m_ov();
    if (rd) begin
      repeat (J) exp_rd.push_back(q.pop_front());
      m_rptr = (m_rptr + J) % SIZE;
    end
    if (wr) begin
      for (int i = 0; i < K; i++) q.push_back(tok + i);
      tok    += K;
      m_wptr  = (m_wptr + K) % SIZE;
      n_acc++;
    end
    if (m_flush) begin
      if (q.size() < J) begin
        q.delete();
        m_rptr  = m_wptr;
        m_flush = 0;
      end
    end else if (f) begin
      m_flush = 1;
    end
    pend = v && !wr;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #1;
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count",     count,     0);
    chk("rst_empty",     empty,     1);
    chk("rst_full",      full,      0);
    chk("rst_flushing",  flushing,  0);
    chk("rst_write_add", write_add, 0);
    chk("rst_read_add",  read_add,  0);
    chk("rst_sb_drained", exp_rd.size(), 0);
    q.delete();
    exp_rd.delete();
    m_wptr = 0; m_rptr = 0; m_flush = 0; pend = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: emulates the Buffer storage and checks every DUT read beat against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        chk("count_le_size", count <= SIZE, 1);
        if (ld)
          for (int i = 0; i < K; i++) mem[(int'(write_add) + i) % SIZE] = cur_tok + i;
        if (out_valid && out_ready) begin
          for (int i = 0; i < J; i++) begin
            if (exp_rd.size() == 0) chk("rd_unexpected_beat", 1, 0);
            else chk("rd_word", mem[(int'(read_add) + i) % SIZE], exp_rd.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, guard, pct;
    bit v;
    do_reset();

    // Two writes, then idle: out_valid rises after the second write.
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    chk("two_wr_write_add", write_add, 8);
    chk("two_wr_out_valid", out_valid, 1);
    chk("two_wr_read_add",  read_add,  0);

    // Fill to full; a fifth beat must be refused.
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    chk("full_flag",     full,     1);
    chk("full_in_ready", in_ready, 0);
    chk("full_ld",       ld,       0);
    cycle(0, 1, 0);

    // From count 8: simultaneous write and read.
    cycle(1, 1, 0);
    cycle(0, 0, 0);
    chk("wr_rd_count",     count,     4);
    chk("wr_rd_out_valid", out_valid, 0);

    // Sustained wrap traffic: 10 writes, drained by reads.
    do_reset();
    base = n_acc;
    guard = 0;
    while (((n_acc - base) < 10 || q.size() > 0) && guard < 60) begin
      cycle((n_acc - base) < 10, 1, 0);
      guard++;
    end
    cycle(0, 0, 0);
    chk("wrap_final_count", count, 0);
    chk("wrap_guard", guard < 60, 1);

    // Flush at count 12: one read, then realignment.
    do_reset();
    repeat (3) cycle(1, 0, 0);
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    chk("flush_flushing", flushing, 1);
    chk("flush_in_ready", in_ready, 0);
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    chk("flush_count",    count,    0);
    chk("flush_read_add", read_add, 12);
    chk("flush_state",    flushing, 0);

    // Reset while in FLUSH.
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    chk("preflush_flushing", flushing, 1);
    do_reset();

    // Randomized traffic with varying read pressure and occasional flushes.
    for (int c = 0; c < 2400; c++) begin
      pct = (c / 200) % 3 == 0 ? 20 : ((c / 200) % 3 == 1 ? 50 : 85);
      v = pend ? 1'b1 : ($urandom_range(0, 3) != 0);
      cycle(v, $urandom_range(0, 99) < pct, $urandom_range(0, 59) == 0);
    end
    cycle(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
